// File: rtl/regfile_mp_pkg.sv
// Shared constants, address-legality rule and lane-slice helper for regfile_mp.
// Optional write-to-read bypass is enabled by defining REGFILE_MP_BYPASS_EN.
`ifndef RF_LANE
`define RF_LANE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  // Legal means backed by a real entry that is not the hardwired zero register.
  function automatic logic addr_legal(input int unsigned addr,
                                      input int unsigned depth,
                                      input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of regfile_mp: flattened write and read lanes.
// valid/ready: reads have no backpressure; rvalid[j] is high for exactly the cycle after re[j].
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
);
  localparam int AW = $clog2(DEPTH);

  logic [NWRITE-1:0]       we;
  logic [NWRITE*AW-1:0]    waddr;
  logic [NWRITE*WIDTH-1:0] wdata;
  logic [NREAD-1:0]        re;
  logic [NREAD*AW-1:0]     raddr;
  logic [NREAD*WIDTH-1:0]  rdata;
  logic [NREAD-1:0]        rvalid;

  modport master (output we, waddr, wdata, re, raddr, input rdata, rvalid);
  modport slave  (input we, waddr, wdata, re, raddr, output rdata, rvalid);
endinterface

// File: rtl/regfile_mp_rdport.sv
// One registered read lane: array mux, illegal-address zeroing and output registers.
// With REGFILE_MP_BYPASS_EN defined, a same-cycle legal write to the read address is forwarded.
import regfile_pkg::*;

module regfile_mp_rdport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
`ifdef REGFILE_MP_BYPASS_EN
  parameter int NWRITE   = 1,
`endif
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DEPTH*WIDTH-1:0]  mem_flat,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
`endif
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid
);

  logic [WIDTH-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    if (addr_legal(int'(raddr), DEPTH, ZERO_REG != 0))
      rd_next = `RF_LANE(mem_flat, int'(raddr), WIDTH);
`ifdef REGFILE_MP_BYPASS_EN
    // Ascending loop: port 1 overrides port 0, matching write priority.
    for (int k = 0; k < NWRITE; k++) begin
      if (we[k] && (`RF_LANE(waddr, k, AW) == raddr) &&
          addr_legal(int'(`RF_LANE(waddr, k, AW)), DEPTH, ZERO_REG != 0))
        rd_next = `RF_LANE(wdata, k, WIDTH);
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= rd_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: array, write-port priority, reset, NREAD read lanes.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle writes to coinciding reads.
import regfile_pkg::*;

module regfile_mp #(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [NREAD*WIDTH-1:0] rdata_flat;
  logic [NREAD-1:0]       rvalid_flat;

  // Later ports are applied last, so port 1 wins a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < NWRITE; k++) begin
        if (bus.we[k] && addr_legal(int'(`RF_LANE(bus.waddr, k, AW)), DEPTH, ZERO_REG != 0))
          mem[`RF_LANE(bus.waddr, k, AW)] <= `RF_LANE(bus.wdata, k, WIDTH);
      end
    end
  end

  always_comb begin
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) `RF_LANE(mem_flat, i, WIDTH) = mem[i];
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    regfile_mp_rdport #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
`ifdef REGFILE_MP_BYPASS_EN
      .NWRITE   (NWRITE),
`endif
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_rdport (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .mem_flat (mem_flat),
`ifdef REGFILE_MP_BYPASS_EN
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
`endif
      .re       (bus.re[j]),
      .raddr    (bus.raddr[j*AW +: AW]),
      .rdata    (rdata_flat[j*WIDTH +: WIDTH]),
      .rvalid   (rvalid_flat[j])
    );
  end

  assign bus.rdata  = rdata_flat;
  assign bus.rvalid = rvalid_flat;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table-driven bench for regfile_mp (DEPTH=24, NREAD=2, NWRITE=2, ZERO_REG=1).
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 24;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(2), .NWRITE(2)) rf_if ();

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (rf_if.slave)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        chk;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [1:0]  expv;
  } vec_t;

  vec_t vecs[$];

`ifdef REGFILE_MP_BYPASS_EN
  localparam logic [31:0] SAME_CYC_RD = 32'h0000_0011;
  localparam logic [31:0] DUAL_BYP_RD = 32'h0000_0055;
`else
  localparam logic [31:0] SAME_CYC_RD = 32'h0000_0022;
  localparam logic [31:0] DUAL_BYP_RD = 32'h0000_0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] we,
                       input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    rst          = r;
    rf_if.we     = we;
    rf_if.waddr  = {wa1, wa0};
    rf_if.wdata  = {wd1, wd0};
    rf_if.re     = re;
    rf_if.raddr  = {ra1, ra0};
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [31:0] e0,
                            input logic [31:0] e1, input logic [1:0] ev);
    check({name, ".rdata0"}, rf_if.rdata[31:0], e0);
    check({name, ".rdata1"}, rf_if.rdata[63:32], e1);
    check({name, ".rvalid"}, {30'd0, rf_if.rvalid}, {30'd0, ev});
  endtask

  task automatic add(input string n, input logic r, input logic [1:0] we,
                     input logic [4:0] wa0, input logic [31:0] wd0,
                     input logic [4:0] wa1, input logic [31:0] wd1,
                     input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic chk, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [1:0] ev);
    vec_t v;
    v.name = n; v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.chk = chk; v.exp0 = e0; v.exp1 = e1; v.expv = ev;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    rf_if.we = '0; rf_if.waddr = '0; rf_if.wdata = '0; rf_if.re = '0; rf_if.raddr = '0;

    //   name          rst we   wa0 wd0           wa1 wd1           re   ra0 ra1 chk exp0          exp1          ev
    add("reset",       1, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 0, 0, 1, 32'h0,        32'h0,        2'b00);
    add("wr5",         0, 2'b01, 5, 32'hDEADBEEF, 0, 32'h0,        2'b00, 0, 0, 1, 32'h0,        32'h0,        2'b00);
    add("rd5",         0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 5, 0, 1, 32'hDEADBEEF, 32'h0,        2'b01);
    add("rst_mid",     1, 2'b00, 0, 32'h0,        0, 32'h0,        2'b00, 0, 0, 1, 32'h0,        32'h0,        2'b00);
    add("rd5_cleared", 0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 5, 0, 1, 32'h0,        32'h0,        2'b01);
    add("wr0",         0, 2'b01, 0, 32'h12345678, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        2'b00);
    add("rd0",         0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 0, 0, 1, 32'h0,        32'h0,        2'b11);
    add("collide7",    0, 2'b11, 7, 32'hAAAA0000, 7, 32'h5555FFFF, 2'b00, 0, 0, 0, 32'h0,        32'h0,        2'b00);
    add("rd7_both",    0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 7, 7, 1, 32'h5555FFFF, 32'h5555FFFF, 2'b11);
    add("wr3_old",     0, 2'b01, 3, 32'h00000022, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        2'b00);
    add("rw3_same",    0, 2'b01, 3, 32'h00000011, 0, 32'h0,        2'b11, 3, 7, 1, SAME_CYC_RD,  32'h5555FFFF, 2'b11);
    add("rd3_next",    0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b01, 3, 7, 1, 32'h00000011, 32'h5555FFFF, 2'b01);
    add("wr_oor_23",   0, 2'b11, 23, 32'hCAFE0023, 30, 32'hFFFFFFFF, 2'b00, 0, 0, 1, 32'h00000011, 32'h5555FFFF, 2'b00);
    add("rd30_23",     0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 30, 23, 1, 32'h0,      32'hCAFE0023, 2'b11);
    add("rd6_alias",   0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 6, 31, 1, 32'h0,       32'h0,        2'b11);
    add("wr9",         0, 2'b01, 9, 32'h00000099, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0,        2'b00);
    add("rst_wr9",     1, 2'b01, 9, 32'h00000001, 0, 32'h0,        2'b11, 9, 9, 1, 32'h0,        32'h0,        2'b00);
    add("rd9_5",       0, 2'b00, 0, 32'h0,        0, 32'h0,        2'b11, 9, 5, 1, 32'h0,        32'h0,        2'b11);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
            vecs[i].re, vecs[i].ra0, vecs[i].ra1);
      if (vecs[i].chk) check_outs(vecs[i].name, vecs[i].exp0, vecs[i].exp1, vecs[i].expv);
    end

    // Both ports write addr 4 while port 0 reads it, then read it back.
    drive(0, 2'b11, 4, 32'h44, 4, 32'h55, 2'b01, 4, 0);
    check_outs("dual_wr_rd4", DUAL_BYP_RD, 32'h0, 2'b01);
    drive(0, 2'b00, 0, 32'h0, 0, 32'h0, 2'b10, 0, 4);
    check_outs("rd4_after", DUAL_BYP_RD, 32'h55, 2'b10);

    // Bypass must not forward an illegal write: write to reg 0 while reading it.
    drive(0, 2'b10, 0, 32'h0, 0, 32'hBAD0BAD0, 2'b11, 0, 0);
    check_outs("rw0_nobyp", 32'h0, 32'h0, 2'b11);

    // Idle cycle: both valids drop, data lanes hold.
    drive(0, 2'b00, 0, 32'h0, 0, 32'h0, 2'b00, 0, 0);
    check_outs("idle_hold", 32'h0, 32'h0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
